decode_int: RTL

- Decode stage directly upstream of the integer execute stage.
- Accepts 32-bit instructions and their addresses from fetch over a valid/ready handshake.
- Splits each instruction into RISC-V base-format fields, classifies it as integer-ALU / other / illegal, and presents one registered decoded instruction per cycle to execute.
- Contains a 1-entry skid buffer so `fetch_ready` depends only on registers, plus stall and flush support.

---
 rtl/decode_int_if.sv | 38 +++
 rtl/decode_int.sv | 114 +++++++++++
 2 files changed

// File: rtl/decode_int_if.sv
// Fetch-to-decode handshake plus the decoded-instruction bundle presented to execute.
interface decode_int_if #(
  parameter int ALEN = 64
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_instruction;
  logic [ALEN-1:0] fetch_instruction_addr;
  logic            exec_stall;
  logic            flush;
  logic            decode_valid;
  logic            decode_is_int;
  logic            decode_illegal;
  logic [ALEN-1:0] decode_instruction_addr;
  logic [4:0]      decode_opcode;
  logic [4:0]      decode_rd;
  logic [2:0]      decode_funct3;
  logic [4:0]      decode_rs1;
  logic [4:0]      decode_rs2;
  logic [6:0]      decode_funct7;
  logic [19:0]     decode_u_imm;

  // Decode stage view.
  modport slave (
    input  fetch_valid, fetch_instruction, fetch_instruction_addr, exec_stall, flush,
    output fetch_ready, decode_valid, decode_is_int, decode_illegal, decode_instruction_addr,
           decode_opcode, decode_rd, decode_funct3, decode_rs1, decode_rs2, decode_funct7,
           decode_u_imm
  );

  // Fetch/execute (environment) view.
  modport master (
    output fetch_valid, fetch_instruction, fetch_instruction_addr, exec_stall, flush,
    input  fetch_ready, decode_valid, decode_is_int, decode_illegal, decode_instruction_addr,
           decode_opcode, decode_rd, decode_funct3, decode_rs1, decode_rs2, decode_funct7,
           decode_u_imm
  );
endinterface

// File: rtl/decode_int.sv
// Integer decode stage: registered output stage backed by a one-entry skid buffer,
// so fetch_ready is a pure register output. Flush empties both entries.
module decode_int #(
  parameter int ALEN = 64
) (
  input logic         clk,
  input logic         rst,
  decode_int_if.slave bus
);

  logic            out_valid, out_valid_d;
  logic            out_is_int, out_illegal;
  logic [31:0]     out_instr;
  logic [ALEN-1:0] out_addr;

  logic            skid_valid, skid_valid_d;
  logic [31:0]     skid_instr;
  logic [ALEN-1:0] skid_addr;

  logic            xfer;
  logic            load_out, load_skid;
  logic [31:0]     sel_instr;
  logic [ALEN-1:0] sel_addr;
  logic            sel_illegal, sel_is_int;

  assign bus.fetch_ready = !skid_valid;
  assign xfer            = bus.fetch_valid && !skid_valid;

  // The skid entry is always older than anything fetch presents, so it wins the source select.
  assign sel_instr = skid_valid ? skid_instr : bus.fetch_instruction;
  assign sel_addr  = skid_valid ? skid_addr  : bus.fetch_instruction_addr;

  // Classify the selected instruction before it is registered.
  always_comb begin
    sel_illegal = (sel_instr[1:0] != 2'b11) || (sel_instr[4:2] == 3'b111) || (sel_instr == 32'h0);
    sel_is_int  = 1'b0;
    if (!sel_illegal) begin
      case (sel_instr[6:2])
        5'b01101, 5'b00101, 5'b01100, 5'b00100, 5'b01110, 5'b00110: sel_is_int = 1'b1;
        default:                                                    sel_is_int = 1'b0;
      endcase
    end
  end

  // Decide what the output stage and skid do this cycle; flush beats everything but reset.
  always_comb begin
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    load_out     = 1'b0;
    load_skid    = 1'b0;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!bus.exec_stall) begin
      if (skid_valid) begin
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
        load_out     = 1'b1;
      end else begin
        out_valid_d = xfer;
        load_out    = xfer;
      end
    end else if (xfer) begin
      if (out_valid) begin
        skid_valid_d = 1'b1;
        load_skid    = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        load_out    = 1'b1;
      end
    end
  end

  // Valid flags carry the reset; payloads need none since they are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      out_valid  <= out_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // Capture payloads for whichever entry is being loaded.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_instr   <= sel_instr;
      out_addr    <= sel_addr;
      out_is_int  <= sel_is_int;
      out_illegal <= sel_illegal;
    end
    if (load_skid) begin
      skid_instr <= bus.fetch_instruction;
      skid_addr  <= bus.fetch_instruction_addr;
    end
  end

  assign bus.decode_valid            = out_valid;
  assign bus.decode_is_int           = out_is_int;
  assign bus.decode_illegal          = out_illegal;
  assign bus.decode_instruction_addr = out_addr;
  assign bus.decode_opcode           = out_instr[6:2];
  assign bus.decode_rd               = out_instr[11:7];
  assign bus.decode_funct3           = out_instr[14:12];
  assign bus.decode_rs1              = out_instr[19:15];
  assign bus.decode_rs2              = out_instr[24:20];
  assign bus.decode_funct7           = out_instr[31:25];
  assign bus.decode_u_imm            = out_instr[31:12];

  logic unused_low;
  assign unused_low = ^out_instr[1:0];

endmodule
